// File: rtl/bsg_cam_nr1w_tag_array_lru.sv
// Fully associative tag CAM with N combinational lookup ports, one allocate port,
// an invalidate-by-tag port, a flush, and true-LRU replacement via an age matrix.
module bsg_cam_nr1w_tag_array_lru #(
  parameter int width_p      = 8,
  parameter int els_p        = 4,
  parameter int read_ports_p = 1,
  parameter int lg_els_lp    = $clog2(els_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            alloc_v_i,
  input  logic [width_p-1:0]              alloc_tag_i,
  output logic                            alloc_ready_o,
  output logic [lg_els_lp-1:0]            alloc_idx_o,
  output logic                            alloc_evict_v_o,
  output logic [width_p-1:0]              alloc_evict_tag_o,
  input  logic                            clr_v_i,
  input  logic [width_p-1:0]              clr_tag_i,
  input  logic                            flush_v_i,
  input  logic [read_ports_p-1:0]         r_v_i,
  input  logic [read_ports_p*width_p-1:0] r_tag_i,
  output logic [read_ports_p*els_p-1:0]   r_match_o,
  output logic [read_ports_p-1:0]         r_hit_o,
  input  logic [lg_els_lp-1:0]            snoop_addr_i,
  output logic                            snoop_v_o,
  output logic [width_p-1:0]              snoop_tag_o,
  output logic [els_p-1:0]                empty_o,
  output logic                            full_o
);

  // r_age[i][j] set: entry i is older than entry j. Diagonal bits are unused.
  logic [els_p-1:0]   r_valid;
  logic [width_p-1:0] r_tag [els_p];
  logic [els_p-1:0]   r_age [els_p];

  logic [read_ports_p*els_p-1:0] w_match;
  logic [els_p-1:0]              w_alloc_match;
  logic [els_p-1:0]              w_clr_match;
  logic [els_p-1:0]              w_row;
  logic [els_p-1:0]              w_age_n [els_p];
  logic                          w_alloc_reuse;
  logic                          w_any_empty;
  logic                          w_xfer;
  logic [lg_els_lp-1:0]          w_reuse_idx;
  logic [lg_els_lp-1:0]          w_empty_idx;
  logic [lg_els_lp-1:0]          w_lru_idx;
  logic [lg_els_lp-1:0]          w_target_idx;

  always_comb begin
    w_match = '0;
    for (int p = 0; p < read_ports_p; p++) begin
      for (int i = 0; i < els_p; i++) begin
        w_match[p*els_p+i] = r_v_i[p] & r_valid[i] &
                             (r_tag[i] == r_tag_i[p*width_p +: width_p]);
      end
    end
  end

  always_comb begin
    r_hit_o = '0;
    for (int p = 0; p < read_ports_p; p++) begin
      r_hit_o[p] = |w_match[p*els_p +: els_p];
    end
  end

  always_comb begin
    w_alloc_match = '0;
    w_clr_match   = '0;
    for (int i = 0; i < els_p; i++) begin
      w_alloc_match[i] = r_valid[i] & (r_tag[i] == alloc_tag_i);
      w_clr_match[i]   = r_valid[i] & (r_tag[i] == clr_tag_i);
    end
  end

  // Descending scan so the lowest qualifying index wins each encoder.
  always_comb begin
    w_reuse_idx = '0;
    w_empty_idx = '0;
    w_lru_idx   = '0;
    w_row       = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      if (w_alloc_match[i]) w_reuse_idx = lg_els_lp'(i);
      if (!r_valid[i])      w_empty_idx = lg_els_lp'(i);
      w_row    = r_age[i];
      w_row[i] = 1'b1;
      if (&w_row)           w_lru_idx   = lg_els_lp'(i);
    end
  end

  // Allocate handshake: a transfer happens on a cycle where alloc_v_i and
  // alloc_ready_o are both high; ready depends only on flush/clr, never on alloc_v_i.
  assign alloc_ready_o     = ~flush_v_i & ~clr_v_i;
  assign w_xfer            = alloc_v_i & alloc_ready_o;
  assign w_alloc_reuse     = |w_alloc_match;
  assign w_any_empty       = ~&r_valid;
  assign w_target_idx      = w_alloc_reuse ? w_reuse_idx :
                             (w_any_empty ? w_empty_idx : w_lru_idx);
  assign alloc_idx_o       = w_target_idx;
  assign alloc_evict_v_o   = alloc_v_i & ~w_alloc_reuse & ~w_any_empty;
  assign alloc_evict_tag_o = r_tag[w_lru_idx];

  assign r_match_o   = w_match;
  assign snoop_v_o   = r_valid[snoop_addr_i];
  assign snoop_tag_o = r_tag[snoop_addr_i];
  assign empty_o     = ~r_valid;
  assign full_o      = &r_valid;

  // Read hits are applied in port order, then the allocate target, so it ends newest.
  always_comb begin
    w_age_n = r_age;
    for (int p = 0; p < read_ports_p; p++) begin
      for (int k = 0; k < els_p; k++) begin
        if (w_match[p*els_p+k]) begin
          for (int j = 0; j < els_p; j++) begin
            if (j != k) begin
              w_age_n[k][j] = 1'b0;
              w_age_n[j][k] = 1'b1;
            end
          end
        end
      end
    end
    if (w_xfer) begin
      for (int j = 0; j < els_p; j++) begin
        if (j != int'(w_target_idx)) begin
          w_age_n[w_target_idx][j] = 1'b0;
          w_age_n[j][w_target_idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_valid <= '0;
      for (int i = 0; i < els_p; i++) begin
        for (int j = 0; j < els_p; j++) begin
          r_age[i][j] <= (i < j);
        end
      end
    end else begin
      r_age <= w_age_n;
      if (flush_v_i) begin
        r_valid <= '0;
      end else if (clr_v_i) begin
        r_valid <= r_valid & ~w_clr_match;
      end else if (w_xfer && !w_alloc_reuse) begin
        r_valid[w_target_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i && w_xfer && !w_alloc_reuse) begin
      r_tag[w_target_idx] <= alloc_tag_i;
    end
  end

  for (genvar gp = 0; gp < read_ports_p; gp++) begin : g_onehot_chk
    always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
        assert ($onehot0(w_match[gp*els_p +: els_p]));
      end
    end
  end

endmodule

// File: tb/tb_bsg_cam_nr1w_tag_array_lru.sv
// Directed plus randomized bench for the LRU tag CAM; the reference keeps a
// recency queue (oldest first) and per-entry valid/tag arrays.
module tb_bsg_cam_nr1w_tag_array_lru;
  localparam int W = 8;
  localparam int N = 4;
  localparam int P = 2;
  localparam int LG = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           alloc_v;
  logic [W-1:0]   alloc_tag;
  logic           alloc_ready;
  logic [LG-1:0]  alloc_idx;
  logic           evict_v;
  logic [W-1:0]   evict_tag;
  logic           clr_v;
  logic [W-1:0]   clr_tag;
  logic           flush_v;
  logic [P-1:0]   r_v;
  logic [W-1:0]   r_tag0, r_tag1;
  logic [P*N-1:0] r_match;
  logic [P-1:0]   r_hit;
  logic [LG-1:0]  snoop_addr;
  logic           snoop_v;
  logic [W-1:0]   snoop_tag;
  logic [N-1:0]   empty;
  logic           full;

  bsg_cam_nr1w_tag_array_lru #(.width_p(W), .els_p(N), .read_ports_p(P)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .alloc_v_i(alloc_v), .alloc_tag_i(alloc_tag), .alloc_ready_o(alloc_ready),
    .alloc_idx_o(alloc_idx), .alloc_evict_v_o(evict_v), .alloc_evict_tag_o(evict_tag),
    .clr_v_i(clr_v), .clr_tag_i(clr_tag), .flush_v_i(flush_v),
    .r_v_i(r_v), .r_tag_i({r_tag1, r_tag0}), .r_match_o(r_match), .r_hit_o(r_hit),
    .snoop_addr_i(snoop_addr), .snoop_v_o(snoop_v), .snoop_tag_o(snoop_tag),
    .empty_o(empty), .full_o(full)
  );

  int checks = 0;
  int errors = 0;

  logic         m_valid [N];
  logic [W-1:0] m_tag [N];
  int           lru_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find_tag(input logic [W-1:0] t);
    for (int i = 0; i < N; i++) if (m_valid[i] && m_tag[i] == t) return i;
    return -1;
  endfunction

  function automatic int first_empty();
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int exp_target(input logic [W-1:0] t);
    int r;
    r = find_tag(t);
    if (r >= 0) return r;
    r = first_empty();
    if (r >= 0) return r;
    return lru_q[0];
  endfunction

  function automatic logic [N-1:0] exp_match(input logic v, input logic [W-1:0] t);
    logic [N-1:0] m;
    m = '0;
    if (v) for (int i = 0; i < N; i++) if (m_valid[i] && m_tag[i] == t) m[i] = 1'b1;
    return m;
  endfunction

  task automatic touch(input int k);
    for (int n = 0; n < lru_q.size(); n++) begin
      if (lru_q[n] == k) begin
        lru_q.delete(n);
        break;
      end
    end
    lru_q.push_back(k);
  endtask

  task automatic drive(input logic rs, input logic av, input logic [W-1:0] at,
                       input logic cv, input logic [W-1:0] ct, input logic fv,
                       input logic [P-1:0] rv, input logic [W-1:0] rt0, input logic [W-1:0] rt1);
    rst_n = rs; alloc_v = av; alloc_tag = at; clr_v = cv; clr_tag = ct;
    flush_v = fv; r_v = rv; r_tag0 = rt0; r_tag1 = rt1;
    snoop_addr = LG'($urandom_range(0, N - 1));
  endtask

  task automatic settle();
    logic [N-1:0] em0, em1, ee;
    logic ev;
    #1;
    em0 = exp_match(r_v[0], r_tag0);
    em1 = exp_match(r_v[1], r_tag1);
    check("ready", 32'(alloc_ready), 32'(!flush_v && !clr_v));
    check("match0", 32'(r_match[N-1:0]), 32'(em0));
    check("match1", 32'(r_match[2*N-1:N]), 32'(em1));
    check("hit", 32'(r_hit), 32'({|em1, |em0}));
    ee = '0;
    for (int i = 0; i < N; i++) ee[i] = !m_valid[i];
    check("empty", 32'(empty), 32'(ee));
    check("full", 32'(full), 32'(ee == '0));
    check("snoop_v", 32'(snoop_v), 32'(m_valid[snoop_addr]));
    if (m_valid[snoop_addr]) check("snoop_tag", 32'(snoop_tag), 32'(m_tag[snoop_addr]));
    if (alloc_v) begin
      ev = (find_tag(alloc_tag) < 0) && (first_empty() < 0);
      check("alloc_idx", 32'(alloc_idx), 32'(exp_target(alloc_tag)));
      check("evict_v", 32'(evict_v), 32'(ev));
      if (ev) check("evict_tag", 32'(evict_tag), 32'(m_tag[lru_q[0]]));
    end
  endtask

  task automatic tick();
    int tgt, h0, h1, ci;
    logic reuse;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      lru_q = {0, 1, 2, 3};
    end else begin
      tgt   = exp_target(alloc_tag);
      reuse = find_tag(alloc_tag) >= 0;
      h0    = r_v[0] ? find_tag(r_tag0) : -1;
      h1    = r_v[1] ? find_tag(r_tag1) : -1;
      ci    = find_tag(clr_tag);
      if (h0 >= 0) touch(h0);
      if (h1 >= 0) touch(h1);
      if (flush_v) begin
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
      end else if (clr_v) begin
        if (ci >= 0) m_valid[ci] = 1'b0;
      end else if (alloc_v) begin
        if (!reuse) begin
          m_tag[tgt]   = alloc_tag;
          m_valid[tgt] = 1'b1;
        end
        touch(tgt);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // First edge establishes state; nothing meaningful to compare before it.
    drive(1'b0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 2'b00, 8'h0, 8'h0);
    tick();
    drive(1'b0, 1'b1, 8'hA, 1'b0, 8'h0, 1'b0, 2'b11, 8'hA, 8'hB);
    settle();
    check("rst_empty", 32'(empty), 32'hF);
    check("rst_full", 32'(full), 32'h0);
    check("rst_hit", 32'(r_hit), 32'h0);
    tick();

    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 8'(8'hA + k), 1'b0, 8'h0, 1'b0, 2'b00, 8'h0, 8'h0);
      settle();
      check("fill_idx", 32'(alloc_idx), k);
      check("fill_noevict", 32'(evict_v), 32'h0);
      tick();
    end
    drive(1'b1, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 2'b00, 8'h0, 8'h0);
    settle();
    check("fill_full", 32'(full), 32'h1);
    tick();

    drive(1'b1, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 2'b01, 8'hA, 8'h0);
    settle();
    check("readA_hit", 32'(r_hit[0]), 32'h1);
    tick();
    drive(1'b1, 1'b1, 8'hE, 1'b0, 8'h0, 1'b0, 2'b00, 8'h0, 8'h0);
    settle();
    check("victim_idx", 32'(alloc_idx), 32'h1);
    check("victim_ev", 32'(evict_v), 32'h1);
    check("victim_tag", 32'(evict_tag), 32'hB);
    tick();

    drive(1'b1, 1'b1, 8'hC, 1'b0, 8'h0, 1'b0, 2'b00, 8'h0, 8'h0);
    settle();
    check("reuse_idx", 32'(alloc_idx), 32'h2);
    check("reuse_noevict", 32'(evict_v), 32'h0);
    tick();
    drive(1'b1, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 2'b00, 8'h0, 8'h0);
    settle();
    check("reuse_stillfull", 32'(empty), 32'h0);
    tick();

    drive(1'b1, 1'b1, 8'hF, 1'b1, 8'hC, 1'b0, 2'b00, 8'h0, 8'h0);
    settle();
    check("clr_ready", 32'(alloc_ready), 32'h0);
    tick();
    drive(1'b1, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 2'b00, 8'h0, 8'h0);
    settle();
    check("clr_empty", 32'(empty), 32'h4);
    tick();

    drive(1'b1, 1'b1, 8'hF, 1'b0, 8'h0, 1'b0, 2'b00, 8'h0, 8'h0);
    settle();
    check("refill_idx", 32'(alloc_idx), 32'h2);
    tick();
    drive(1'b1, 1'b1, 8'h11, 1'b0, 8'h0, 1'b1, 2'b00, 8'h0, 8'h0);
    settle();
    check("flush_ready", 32'(alloc_ready), 32'h0);
    tick();
    drive(1'b1, 1'b1, 8'h11, 1'b0, 8'h0, 1'b0, 2'b00, 8'h0, 8'h0);
    settle();
    check("flush_empty", 32'(empty), 32'hF);
    check("flush_idx", 32'(alloc_idx), 32'h0);
    tick();

    // Reset on top of a live allocate must discard it.
    drive(1'b0, 1'b1, 8'h22, 1'b0, 8'h0, 1'b0, 2'b01, 8'h11, 8'h0);
    settle();
    tick();
    drive(1'b1, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 2'b11, 8'h11, 8'h22);
    settle();
    check("midrst_empty", 32'(empty), 32'hF);
    check("midrst_hit", 32'(r_hit), 32'h0);
    tick();

    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 8'(8'hA + k), 1'b0, 8'h0, 1'b0, 2'b00, 8'h0, 8'h0);
      settle();
      tick();
    end
    drive(1'b1, 1'b0, 8'h0, 1'b0, 8'h0, 1'b0, 2'b11, 8'hA, 8'hC);
    settle();
    check("dual_hit", 32'(r_hit), 32'h3);
    check("dual_match", 32'(r_match), 32'h41);
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [7:0] exp_order;
      exp_order = 8'b10_00_11_01; // idx 1,3,0,2 as 2-bit fields, low first
      drive(1'b1, 1'b1, 8'(8'h30 + k), 1'b0, 8'h0, 1'b0, 2'b00, 8'h0, 8'h0);
      settle();
      check("dual_victim", 32'(alloc_idx), 32'(exp_order[2*k +: 2]));
      tick();
    end

    for (int n = 0; n < 600; n++) begin
      drive(1'b1, ($urandom_range(0, 2) != 0), 8'(8'hA0 + $urandom_range(0, 6)),
            ($urandom_range(0, 7) == 0), 8'(8'hA0 + $urandom_range(0, 6)),
            ($urandom_range(0, 39) == 0), 2'($urandom_range(0, 3)),
            8'(8'hA0 + $urandom_range(0, 6)), 8'(8'hA0 + $urandom_range(0, 6)));
      if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_cam_nr1w_tag_array_lru.md
BSG_CAM_NR1W_TAG_ARRAY_LRU -- requirements
Module: bsg_cam_nr1w_tag_array_lru

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- width_p, none, tag width.
- els_p, none, entry count; must be at least 2.
- read_ports_p, 1, number of independent associative read ports.
- lg_els_lp, derived as ceil(log2(els_p)).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  sole clock.
- reset_n_i  in  1  reset; synchronous, active-low.
- alloc_v_i  in  1  allocate request.
- alloc_tag_i  in  width_p  tag to install.
- alloc_ready_o  out  1  allocate accepted this cycle.
- alloc_idx_o  out  lg_els_lp  entry written or reused.
- alloc_evict_v_o  out  1  a valid entry is being replaced.
- alloc_evict_tag_o  out  width_p  tag of the replaced entry.
- clr_v_i  in  1  invalidate the entry matching clr_tag_i.
- clr_tag_i  in  width_p  tag to invalidate.
- flush_v_i  in  1  invalidate all entries.
- r_v_i  in  read_ports_p  per-port lookup valid.
- r_tag_i  in  read_ports_p x width_p  per-port lookup tag.
- r_match_o  out  read_ports_p x els_p  per-port one-hot or zero-hot match.
- r_hit_o  out  read_ports_p  OR-reduction of each port's r_match_o row.
- snoop_addr_i  in  lg_els_lp  debug index.
- snoop_v_o  out  1  valid bit at snoop_addr_i.
- snoop_tag_o  out  width_p  tag at snoop_addr_i.
- empty_o  out  els_p  per-entry not-valid vector.
- full_o  out  1  all entries valid.

Function
REQ-003 State SHALL be per-entry valid bit, per-entry tag register, and an els_p x els_p LRU age matrix (bit [i][j] set means i is older than j).
REQ-004 Reads SHALL be combinational on current state: r_match_o[p][i] = r_v_i[p] & valid[i] & (tag[i] == r_tag_i[p]); writes in the same cycle SHALL NOT be visible until the next cycle.
REQ-005 A read hit on port p SHALL mark the matched entry most-recently-used at the clock edge; ports SHALL be applied in ascending index order.
REQ-006 Priority per cycle SHALL be flush_v_i, then clr_v_i, then allocate.
REQ-007 alloc_ready_o SHALL equal ~flush_v_i & ~clr_v_i; a transfer occurs when alloc_v_i & alloc_ready_o.
REQ-008 On transfer, if alloc_tag_i matches a valid entry, the module SHALL:
- reuse that entry, with alloc_idx_o set to its index;
- write no tag;
- hold alloc_evict_v_o at 0;
- mark the entry MRU.
REQ-009 Otherwise, on transfer, the target SHALL be the lowest-index empty entry if one exists, else the LRU entry; the module SHALL write the tag, set valid, and mark the target MRU after any read-hit updates.
REQ-010 alloc_evict_v_o SHALL be 1 only when the target was valid and the tag was not reused; alloc_evict_tag_o SHALL then be the old tag.
REQ-011 alloc_idx_o, alloc_evict_v_o and alloc_evict_tag_o SHALL be combinational and valid whenever alloc_v_i is high.
REQ-012 clr_v_i SHALL clear the valid bit of the matching entry next cycle; on a miss it SHALL have no effect; LRU SHALL be unchanged.
REQ-013 flush_v_i SHALL clear all valid bits in one cycle; LRU SHALL be unchanged; read-hit LRU updates in that cycle SHALL still apply.
REQ-014 full_o SHALL equal &valid; empty_o SHALL equal ~valid.
REQ-015 snoop_v_o and snoop_tag_o SHALL be combinational; snoop_tag_o SHALL be unspecified when snoop_v_o is 0.
REQ-016 More than one valid entry with the same tag SHALL be impossible by construction; simulation SHALL assert that r_match_o has at most one bit set per port.

Reset
REQ-017 With reset_n_i low at a clock edge, the module SHALL:
- clear all valid bits;
- set the age matrix so that entry i is older than entry j for all i<j;
- leave tag contents undefined.
REQ-018 During and immediately after reset, outputs SHALL be:
- r_match_o and r_hit_o 0;
- empty_o all ones;
- full_o 0;
- snoop_v_o 0;
- alloc_ready_o per REQ-007.
REQ-019 Reset asserted mid-operation SHALL discard same-cycle alloc, clr, flush and LRU updates.

Verification
REQ-020 els_p=4: reset, then allocate tags 0xA, 0xB, 0xC, 0xD -> alloc_idx_o 0, 1, 2, 3; no evict; full_o=1 after the fourth.
REQ-021 Full with 0xA-0xD: read 0xA, then allocate 0xE -> target idx 1; evict tag 0xB; r_hit_o=1 for 0xA.
REQ-022 Allocate 0xC while present -> alloc_idx_o=2; alloc_evict_v_o=0; no state change except LRU.
REQ-023 clr_v_i with alloc_v_i in the same cycle -> alloc_ready_o=0; the matching entry is cleared next cycle; empty_o shows that bit set.
REQ-024 flush_v_i while full -> next cycle empty_o=all ones; the next allocate goes to idx 0.
REQ-025 read_ports_p=2, both ports hit different entries, then allocate on full -> port-1 entry is MRU; victim is the oldest unread entry.
